wb_prefetch_unit: RTL and testbench
===================================

// Module: wb_prefetch_unit
// PURPOSE
//  Parametrised Wishbone instruction prefetcher. Successor to the CPU's single-shot FETCH/DECODE
//  states: owns the fetch PC and issues classic read cycles ahead of the core. Buffers {pc,instr}
//  pairs in a DEPTH-entry FIFO and supports redirect (flush + new PC), bus-error capture and timeout.
//  Sits between the CPU execute stage and the Wishbone interconnect as a second bus master.
// PARAMETERS
//  DAT_WIDTH  64               instruction/bus data width, bits (multiple of 8)
//  ADR_WIDTH  64               address width, bits
//  DEPTH      4                FIFO entries, power of two, >=2
//  RESET_PC   64'h800000000000 fetch PC after reset
//  TIMEOUT    16               cycles allowed from stb_o rise to ack_i/err_i; 0 disables
// PORTS
//  clk_i           in   1             clock
//  rst_i           in   1             synchronous reset, active high
//  ifu_adr_o       out  ADR_WIDTH     Wishbone address
//  ifu_dat_i       in   DAT_WIDTH     Wishbone read data
//  ifu_sel_o       out  DAT_WIDTH/8   byte selects, all ones during a cycle
//  ifu_we_o        out  1             write enable, constant 0
//  ifu_stb_o       out  1             strobe
//  ifu_cyc_o       out  1             cycle
//  ifu_ack_i       in   1             acknowledge
//  ifu_err_i       in   1             bus error
//  instr_valid_o   out  1             FIFO head valid
//  instr_o         out  DAT_WIDTH     head instruction
//  instr_pc_o      out  ADR_WIDTH     address the head was fetched from
//  instr_ready_i   in   1             consumer pops head when valid&ready
//  redirect_i      in   1             flush and restart fetch at redirect_pc_i
//  redirect_pc_i   in   ADR_WIDTH     new PC; low log2(DAT_WIDTH/8) bits forced to 0
//  fault_o         out  1             fetch halted on error/timeout (sticky until redirect)
//  fault_timeout_o out  1             1 = cause was timeout, 0 = err_i
//  fault_adr_o     out  ADR_WIDTH     address of the faulting cycle
//  level_o         out  $clog2(DEPTH+1) FIFO occupancy
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC; FIFO empty; stb/cyc/we=0, sel=0, adr=0; fault_*=0; level=0; state IDLE.
//  States: IDLE -> BUS when level+inflight<DEPTH and !fault (registered: stb/cyc rise next cycle,
//   adr=fetch_pc, sel=all ones). BUS stays until ack/err/timeout/redirect; always then IDLE for
//   one cycle (stb/cyc low), so zero-wait slave yields 1 instr per 2 cycles. FAULT on err/timeout.
//  ack_i in BUS: push {fetch_pc, dat_i}; fetch_pc += DAT_WIDTH/8 (wraps modulo 2^ADR_WIDTH).
//   Slot reserved at issue, so push never overflows; push+pop same cycle leaves level unchanged.
//  err_i in BUS (ack_i and err_i together: err wins): no push; fault_o=1, fault_timeout_o=0,
//   fault_adr_o=adr; -> FAULT. Entries already queued stay poppable.
//  Timeout: counter clears on entering BUS; reaching TIMEOUT without ack/err -> same as err with
//   fault_timeout_o=1, stb/cyc dropped next cycle.
//  Pop: instr_* combinationally show head; valid&ready removes it; level_o updates next cycle.
//  Redirect (highest priority, any state): next cycle FIFO empty, level 0, fetch_pc=aligned
//   redirect_pc_i, fault_* cleared, stb/cyc dropped (cycle abandoned), ack/err that cycle ignored,
//   pop that cycle ignored; -> IDLE. New fetch issues the cycle after.
//  rst_i mid-cycle: stb/cyc low next edge; all state returns to reset values.
//  Empty: valid=0, instr_o/instr_pc_o hold last-read RAM contents (don't care). Full: no issue.
// STRUCTURE
//  Constants (state encodings, WB widths) go in the shared wishbone/CPU defines header, alongside
//  DAT_WIDTH. One sub-module: sync_fifo (WIDTH=ADR_WIDTH+DAT_WIDTH, DEPTH, push/pop/flush/
//  level, push+pop when full allowed). Top holds FSM, fetch_pc, timeout counter, fault capture.
// TESTING
//  Reset, zero-wait slave, ready=0: cycles at 0x800000000000,+8,+10,+18 then stop; level_o=4.
//  Then ready=1 for 4 cycles: pops in PC order with matching instr_pc_o; fetch resumes at +20.
//  err_i on 3rd cycle (adr +10): fault_o=1, fault_adr_o=0x800000000010, two entries still pop.
//  Slave never acks, TIMEOUT=16: stb drops 16 cycles after rise; fault_timeout_o=1.
//  redirect_i to 0x1003 during BUS with ack same cycle: data dropped, level 0, next adr 0x1000.
//  Fetch from 0xFFFF_FFFF_FFFF_FFF8: next fetch at 0x0; rst_i while stb=1: stb/cyc 0 next edge.

Source files
------------

// File: rtl/wb_prefetch_unit_pkg.sv
// Shared constants for the instruction prefetcher: FSM state encoding and
// default bus geometry used by the interface and the top level.
package wb_prefetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // bus quiet, deciding whether to issue
        ST_BUS   = 2'd1,   // classic read cycle in progress
        ST_FAULT = 2'd2    // halted on err/timeout until redirected
    } fetch_state_e;

    localparam int unsigned WB_DAT_WIDTH = 64;
    localparam int unsigned WB_ADR_WIDTH = 64;
    localparam int unsigned WB_DEPTH     = 4;
    localparam logic [63:0] WB_RESET_PC  = 64'h0000_8000_0000_0000;
    localparam int unsigned WB_TIMEOUT   = 16;

endpackage

// File: rtl/wb_prefetch_unit_if.sv
// Wishbone classic read port of the prefetcher. The prefetcher is the
// master; the interconnect (or a bench slave) takes the slave modport.
interface wb_prefetch_unit_if
    import wb_prefetch_unit_pkg::*;
#(
    parameter int unsigned ADR_WIDTH = WB_ADR_WIDTH,
    parameter int unsigned DAT_WIDTH = WB_DAT_WIDTH
) ();

    logic [ADR_WIDTH-1:0]   adr;
    logic [DAT_WIDTH-1:0]   dat;
    logic [DAT_WIDTH/8-1:0] sel;
    logic                   we;
    logic                   stb;
    logic                   cyc;
    logic                   ack;
    logic                   err;

    modport master (
        output adr, sel, we, stb, cyc,
        input  dat, ack, err
    );

    modport slave (
        input  adr, sel, we, stb, cyc,
        output dat, ack, err
    );

endinterface

// File: rtl/wb_prefetch_unit_sync_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs. Head is visible
// combinationally; push together with pop is accepted even when full.
module wb_prefetch_unit_sync_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [LVL_W-1:0] level_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot the push lands in.
    assign do_push = push_i && (!full || do_pop);
    assign data_o  = mem_q[rd_q];
    assign level_o = level_q;

    // Pointer and occupancy bookkeeping; flush empties in one cycle.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values of its neighbours regardless of statement order.
        if (rst_i || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= rd_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array is deliberately not reset; the occupancy
        // count alone decides which entries are meaningful.
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/wb_prefetch_unit.sv
// Wishbone instruction prefetcher: owns the fetch PC, issues one classic
// read at a time ahead of the core, queues {pc, instr} pairs, and handles
// redirect, bus error and timeout.
module wb_prefetch_unit
    import wb_prefetch_unit_pkg::*;
#(
    parameter int unsigned          DAT_WIDTH = WB_DAT_WIDTH,
    parameter int unsigned          ADR_WIDTH = WB_ADR_WIDTH,
    parameter int unsigned          DEPTH     = WB_DEPTH,
    parameter logic [ADR_WIDTH-1:0] RESET_PC  = ADR_WIDTH'(WB_RESET_PC),
    parameter int unsigned          TIMEOUT   = WB_TIMEOUT,
    localparam int unsigned         LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wb_prefetch_unit_if.master   ifu,
    output logic                 instr_valid_o,
    output logic [DAT_WIDTH-1:0] instr_o,
    output logic [ADR_WIDTH-1:0] instr_pc_o,
    input  logic                 instr_ready_i,
    input  logic                 redirect_i,
    input  logic [ADR_WIDTH-1:0] redirect_pc_i,
    output logic                 fault_o,
    output logic                 fault_timeout_o,
    output logic [ADR_WIDTH-1:0] fault_adr_o,
    output logic [LVL_W-1:0]     level_o
);

    localparam int unsigned          SEL_W      = DAT_WIDTH / 8;
    localparam int unsigned          ADR_LSB    = $clog2(SEL_W);
    localparam logic [ADR_WIDTH-1:0] PC_STEP    = ADR_WIDTH'(SEL_W);
    localparam logic [ADR_WIDTH-1:0] ALIGN_MASK =
        ~((ADR_WIDTH'(1) << ADR_LSB) - ADR_WIDTH'(1));
    localparam int unsigned          TO_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0]      TO_LAST    = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    fetch_state_e           state_q;
    fetch_state_e           state_d;
    logic [ADR_WIDTH-1:0]   fetch_pc_q;
    logic [TO_W-1:0]        to_cnt_q;
    logic                   fault_q;
    logic                   fault_to_q;
    logic [ADR_WIDTH-1:0]   fault_adr_q;

    logic                   bus_active;
    logic                   timed_out;
    logic                   push;
    logic                   pop;
    logic                   fault_set;
    logic                   fault_by_to;
    logic                   fifo_empty;
    logic [ADR_WIDTH+DAT_WIDTH-1:0] fifo_head;

    assign bus_active = (state_q == ST_BUS);
    // The counter reads TO_LAST in the TIMEOUT-th cycle of the strobe.
    assign timed_out  = (TIMEOUT != 0) && bus_active && (to_cnt_q == TO_LAST);

    // Bus outputs derive from registered state only, so they are glitch-free.
    assign ifu.stb = bus_active;
    assign ifu.cyc = bus_active;
    assign ifu.we  = 1'b0;
    assign ifu.sel = bus_active ? {SEL_W{1'b1}} : '0;
    assign ifu.adr = bus_active ? fetch_pc_q : '0;

    // Next-state and per-cycle actions; redirect overrides everything.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned and infers a latch.
        state_d     = state_q;
        push        = 1'b0;
        fault_set   = 1'b0;
        fault_by_to = 1'b0;
        if (redirect_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Only one cycle is ever in flight and none is in IDLE,
                    // so a free FIFO slot is the whole reservation check.
                    if (level_o < LVL_W'(DEPTH)) state_d = ST_BUS;
                end
                ST_BUS: begin
                    if (ifu.err) begin
                        fault_set = 1'b1;
                        state_d   = ST_FAULT;
                    end else if (ifu.ack) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else if (timed_out) begin
                        fault_set   = 1'b1;
                        fault_by_to = 1'b1;
                        state_d     = ST_FAULT;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Strobe-age counter: zero in the first cycle of every bus cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || !bus_active) to_cnt_q <= '0;
        else                      to_cnt_q <= to_cnt_q + TO_W'(1);
    end

    // Fetch PC advance and sticky fault capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q  <= RESET_PC;
            fault_q     <= 1'b0;
            fault_to_q  <= 1'b0;
            fault_adr_q <= '0;
        end else if (redirect_i) begin
            fetch_pc_q  <= redirect_pc_i & ALIGN_MASK;
            fault_q     <= 1'b0;
            fault_to_q  <= 1'b0;
            fault_adr_q <= '0;
        end else begin
            if (push) fetch_pc_q <= fetch_pc_q + PC_STEP;
            if (fault_set) begin
                fault_q     <= 1'b1;
                fault_to_q  <= fault_by_to;
                fault_adr_q <= fetch_pc_q;
            end
        end
    end

    // A redirect discards the queue, so a same-cycle pop is moot.
    assign pop = instr_valid_o && instr_ready_i && !redirect_i;

    wb_prefetch_unit_sync_fifo #(
        .WIDTH (ADR_WIDTH + DAT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .data_i  ({fetch_pc_q, ifu.dat}),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign instr_valid_o   = !fifo_empty;
    assign instr_pc_o      = fifo_head[ADR_WIDTH+DAT_WIDTH-1 -: ADR_WIDTH];
    assign instr_o         = fifo_head[DAT_WIDTH-1:0];
    assign fault_o         = fault_q;
    assign fault_timeout_o = fault_to_q;
    assign fault_adr_o     = fault_adr_q;

endmodule

// File: tb/tb_wb_prefetch_unit.sv
// Scoreboard bench for wb_prefetch_unit: a behavioural Wishbone slave
// answers reads, expected {pc, instr} pairs are queued as fetches are
// predicted and compared when the consumer pops them.
module tb_wb_prefetch_unit;

    localparam int          DW      = 64;
    localparam int          AW      = 64;
    localparam int          DEPTH   = 4;
    localparam int          TIMEOUT = 16;
    localparam logic [63:0] RST_PC  = 64'h0000_8000_0000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] instr;
    } exp_t;

    typedef enum int { SLV_ACK, SLV_SILENT, SLV_ERR } slv_mode_e;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_valid_o;
    logic [63:0] instr_o;
    logic [63:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        fault_o;
    logic        fault_timeout_o;
    logic [63:0] fault_adr_o;
    logic [2:0]  level_o;

    wb_prefetch_unit_if #(.ADR_WIDTH(AW), .DAT_WIDTH(DW)) bus ();

    wb_prefetch_unit #(
        .DAT_WIDTH (DW),
        .ADR_WIDTH (AW),
        .DEPTH     (DEPTH),
        .RESET_PC  (RST_PC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ifu             (bus),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_ready_i   (instr_ready_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .fault_o         (fault_o),
        .fault_timeout_o (fault_timeout_o),
        .fault_adr_o     (fault_adr_o),
        .level_o         (level_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb[$];
    logic [63:0] slv_log[$];
    slv_mode_e   slv_mode    = SLV_ACK;
    int          slv_cycles  = 0;
    int          slv_err_idx = 0;

    // Read data is a fixed scramble of the address.
    function automatic logic [63:0] gen_data(input logic [63:0] a);
        return {~a[31:0], a[31:0] ^ 32'h1357_9BDF};
    endfunction

    // Zero-wait slave: answers in the first strobe cycle, logs each address.
    always @(negedge clk_i) begin
        bus.ack = 1'b0;
        bus.err = 1'b0;
        bus.dat = gen_data(bus.adr);
        if (!rst_i && bus.stb && bus.cyc && slv_mode != SLV_SILENT) begin
            if (slv_mode == SLV_ERR && slv_cycles == slv_err_idx) bus.err = 1'b1;
            else                                                 bus.ack = 1'b1;
            slv_log.push_back(bus.adr);
            slv_cycles++;
        end
    end

    task automatic push_exp(input logic [63:0] pc);
        sb.push_back('{pc: pc, instr: gen_data(pc)});
    endtask

    task automatic apply_reset(input slv_mode_e mode);
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        slv_mode      = mode;
        repeat (3) @(negedge clk_i);
        sb.delete();
        slv_log.delete();
        slv_cycles = 0;
        rst_i = 1'b0;
    endtask

    task automatic wait_stb(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.stb) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
    endtask

    // Pops n entries, comparing each head against the scoreboard front.
    task automatic consume(input int n, input string tag);
        exp_t e;
        int   waited;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            while (!instr_valid_o && waited < 50) begin
                @(negedge clk_i);
                waited++;
            end
            n_checks++;
            if (!instr_valid_o || sb.size() == 0) begin
                $display("FAIL %s_pop%0d: valid=%b queued=%0d, required valid=1 with an expected entry",
                         tag, i, instr_valid_o, sb.size());
                instr_ready_i = 1'b0;
                return;
            end
            n_pass++;
            e = sb.pop_front();
            n_checks++;
            if (instr_pc_o !== e.pc)
                $display("FAIL %s_pc%0d: got %h, required %h", tag, i, instr_pc_o, e.pc);
            else n_pass++;
            n_checks++;
            if (instr_o !== e.instr)
                $display("FAIL %s_instr%0d: got %h, required %h", tag, i, instr_o, e.instr);
            else n_pass++;
            instr_ready_i = 1'b1;
            @(negedge clk_i);
            instr_ready_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({bus.stb, bus.cyc, bus.we} !== 3'b000)
            $display("FAIL reset_stb_cyc_we: got %b, required 000", {bus.stb, bus.cyc, bus.we});
        else n_pass++;
        n_checks++;
        if (bus.sel !== 8'h00) $display("FAIL reset_sel: got %h, required 00", bus.sel);
        else n_pass++;
        n_checks++;
        if (bus.adr !== 64'h0) $display("FAIL reset_adr: got %h, required 0", bus.adr);
        else n_pass++;
        n_checks++;
        if ({fault_o, fault_timeout_o} !== 2'b00 || fault_adr_o !== 64'h0)
            $display("FAIL reset_fault: got %b%b adr %h, required 00 adr 0",
                     fault_o, fault_timeout_o, fault_adr_o);
        else n_pass++;
        n_checks++;
        if (level_o !== 3'd0 || instr_valid_o !== 1'b0)
            $display("FAIL reset_fifo: got level %0d valid %b, required 0 0", level_o, instr_valid_o);
        else n_pass++;
    endtask

    task automatic test_zero_wait_fill();
        apply_reset(SLV_ACK);
        for (int i = 0; i < 4; i++) push_exp(RST_PC + 64'(8 * i));
        repeat (20) @(negedge clk_i);
        n_checks++;
        if (slv_log.size() != 4) $display("FAIL fill_count: got %0d cycles, required 4", slv_log.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < slv_log.size(); i++) begin
            n_checks++;
            if (slv_log[i] !== RST_PC + 64'(8 * i))
                $display("FAIL fill_adr%0d: got %h, required %h", i, slv_log[i], RST_PC + 64'(8 * i));
            else n_pass++;
        end
        n_checks++;
        if (level_o !== 3'd4 || bus.stb !== 1'b0)
            $display("FAIL fill_full: got level %0d stb %b, required 4 0", level_o, bus.stb);
        else n_pass++;
        consume(4, "fill");
        for (int i = 4; i < 8; i++) push_exp(RST_PC + 64'(8 * i));
        repeat (20) @(negedge clk_i);
        n_checks++;
        if (slv_log.size() != 8 || slv_log[4] !== RST_PC + 64'h20)
            $display("FAIL resume_adr: got %0d cycles first %h, required 8 cycles first %h",
                     slv_log.size(), (slv_log.size() > 4) ? slv_log[4] : 64'h0, RST_PC + 64'h20);
        else n_pass++;
        n_checks++;
        if (level_o !== 3'd4) $display("FAIL resume_level: got %0d, required 4", level_o);
        else n_pass++;
        consume(4, "resume");
    endtask

    task automatic test_bus_error();
        slv_err_idx = 2;
        apply_reset(SLV_ERR);
        push_exp(RST_PC);
        push_exp(RST_PC + 64'h8);
        repeat (15) @(negedge clk_i);
        n_checks++;
        if ({fault_o, fault_timeout_o} !== 2'b10)
            $display("FAIL err_flags: got %b%b, required 10", fault_o, fault_timeout_o);
        else n_pass++;
        n_checks++;
        if (fault_adr_o !== RST_PC + 64'h10)
            $display("FAIL err_adr: got %h, required %h", fault_adr_o, RST_PC + 64'h10);
        else n_pass++;
        n_checks++;
        if (level_o !== 3'd2 || bus.stb !== 1'b0 || slv_log.size() != 3)
            $display("FAIL err_halt: got level %0d stb %b cycles %0d, required 2 0 3",
                     level_o, bus.stb, slv_log.size());
        else n_pass++;
        consume(2, "err");
        repeat (5) @(negedge clk_i);
        n_checks++;
        if (level_o !== 3'd0 || fault_o !== 1'b1 || slv_log.size() != 3)
            $display("FAIL err_sticky: got level %0d fault %b cycles %0d, required 0 1 3",
                     level_o, fault_o, slv_log.size());
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        int high;
        apply_reset(SLV_SILENT);
        wait_stb(5, ok);
        n_checks++;
        if (!ok) $display("FAIL to_start: got stb 0, required 1 within 5 cycles");
        else n_pass++;
        high = 0;
        while (bus.stb && high < 40) begin
            high++;
            @(negedge clk_i);
        end
        n_checks++;
        if (high != TIMEOUT) $display("FAIL to_length: got %0d cycles, required %0d", high, TIMEOUT);
        else n_pass++;
        n_checks++;
        if ({fault_o, fault_timeout_o} !== 2'b11 || fault_adr_o !== RST_PC)
            $display("FAIL to_flags: got %b%b adr %h, required 11 adr %h",
                     fault_o, fault_timeout_o, fault_adr_o, RST_PC);
        else n_pass++;
        slv_mode      = SLV_ACK;
        redirect_pc_i = 64'h2000;
        redirect_i    = 1'b1;
        @(negedge clk_i);
        redirect_i = 1'b0;
        n_checks++;
        if ({fault_o, fault_timeout_o} !== 2'b00 || fault_adr_o !== 64'h0)
            $display("FAIL to_clear: got %b%b adr %h, required 00 adr 0",
                     fault_o, fault_timeout_o, fault_adr_o);
        else n_pass++;
        push_exp(64'h2000);
        consume(1, "to_recover");
    endtask

    task automatic test_redirect();
        bit ok;
        apply_reset(SLV_ACK);
        wait_stb(5, ok);
        n_checks++;
        if (!ok) $display("FAIL redir_start: got stb 0, required 1 within 5 cycles");
        else n_pass++;
        redirect_pc_i = 64'h1003;
        redirect_i    = 1'b1;
        @(negedge clk_i);
        redirect_i = 1'b0;
        n_checks++;
        if (level_o !== 3'd0 || instr_valid_o !== 1'b0 || bus.stb !== 1'b0)
            $display("FAIL redir_flush: got level %0d valid %b stb %b, required 0 0 0",
                     level_o, instr_valid_o, bus.stb);
        else n_pass++;
        @(negedge clk_i);
        n_checks++;
        if (bus.stb !== 1'b1 || bus.adr !== 64'h1000)
            $display("FAIL redir_issue: got stb %b adr %h, required 1 adr 1000", bus.stb, bus.adr);
        else n_pass++;
        push_exp(64'h1000);
        push_exp(64'h1008);
        repeat (10) @(negedge clk_i);
        consume(2, "redir");
    endtask

    task automatic test_wrap();
        apply_reset(SLV_ACK);
        redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF8;
        redirect_i    = 1'b1;
        @(negedge clk_i);
        redirect_i = 1'b0;
        push_exp(64'hFFFF_FFFF_FFFF_FFF8);
        push_exp(64'h0);
        push_exp(64'h8);
        push_exp(64'h10);
        repeat (20) @(negedge clk_i);
        n_checks++;
        if (slv_log.size() != 4 || slv_log[1] !== 64'h0)
            $display("FAIL wrap_adr: got %0d cycles second %h, required 4 cycles second 0",
                     slv_log.size(), (slv_log.size() > 1) ? slv_log[1] : 64'hX);
        else n_pass++;
        consume(4, "wrap");
    endtask

    task automatic test_reset_mid_cycle();
        bit ok;
        apply_reset(SLV_SILENT);
        wait_stb(5, ok);
        n_checks++;
        if (!ok) $display("FAIL rst_mid_start: got stb 0, required 1 within 5 cycles");
        else n_pass++;
        rst_i = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if ({bus.stb, bus.cyc} !== 2'b00 || bus.adr !== 64'h0 || level_o !== 3'd0)
            $display("FAIL rst_mid: got stb %b cyc %b adr %h level %0d, required 0 0 0 0",
                     bus.stb, bus.cyc, bus.adr, level_o);
        else n_pass++;
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_wait_fill();
        test_bus_error();
        test_timeout();
        test_redirect();
        test_wrap();
        test_reset_mid_cycle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
